// File: rtl/tate_pairing_host_if_pkg.sv
// Field-size macros shared by the pairing host interface and its bench,
// plus the host FSM state type and operand/result widths.
`ifndef TATE_INC_DEFS
`define TATE_INC_DEFS
`define M 97
`define WIDTH (2*`M-1)
`define W6 (12*`M-1)
`define TATE_NI(dw) ((`WIDTH+(dw))/(dw))
`define TATE_NO(dw) ((`W6+(dw))/(dw))
`endif

package tate_pairing_host_if_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_UNLOAD
    } host_state_e;

    localparam int OP_W  = `WIDTH + 1;
    localparam int RES_W = `W6 + 1;

    // Counter width that still gives one bit when only a single value is needed
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tate_pairing_host_if_word_shifter.sv
// DW-granular result shift register: loads the full core result and presents
// it low word first, shifting zeros in so the last word is zero-padded.
module host_word_shifter #(
    parameter int DW = 32,
    parameter int NO = 37,
    parameter int RW = 1164
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [RW-1:0] load_data,
    input  logic          shift,
    output logic [DW-1:0] word
);

    localparam int SW = NO * DW;

    logic [SW-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= SW'(load_data);
        end else if (shift) begin
            sr <= sr >> DW;
        end
    end

    assign word = sr[DW-1:0];

endmodule

// File: rtl/tate_pairing_host_if.sv
// Host-side initiator for the Tate pairing core: assembles operands from a
// word stream, runs the core, and streams the result and run length back.
module tate_pairing_host_if
    import tate_pairing_host_if_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic [CW-1:0]    cycles,
    output logic             core_reset,
    output logic [`WIDTH:0]  core_x1,
    output logic [`WIDTH:0]  core_y1,
    output logic [`WIDTH:0]  core_x2,
    output logic [`WIDTH:0]  core_y2,
    input  logic             core_done,
    input  logic [`W6:0]     core_out
);

    localparam int NI  = `TATE_NI(DW);
    localparam int NO  = `TATE_NO(DW);
    localparam int WCW = cnt_w(NI);
    localparam int RCW = cnt_w(NO);
    localparam logic [WCW-1:0] W_LAST = WCW'(NI - 1);
    localparam logic [RCW-1:0] R_LAST = RCW'(NO - 1);

    host_state_e state, state_next;

    logic [WCW-1:0]  wcnt;
    logic [1:0]      ocnt;
    logic [RCW-1:0]  rcnt;
    logic [CW-1:0]   run_cnt;
    logic [OP_W-1:0] opr [4];

    logic in_fire, out_fire, done_fire;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign done_fire = core_done && (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // The core is held in reset everywhere except RUN, so each job starts it clean
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        core_reset = 1'b1;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && wcnt == W_LAST && ocnt == 2'd3) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                core_reset = 1'b0;
                if (core_done) begin
                    state_next = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready && rcnt == R_LAST) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    assign out_last = out_valid && (rcnt == R_LAST);
    assign busy     = (state != ST_LOAD) || (wcnt != '0) || (ocnt != '0);

    // Only the addressed word of the current operand changes; bits past the operand width are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt <= '0;
            ocnt <= '0;
            for (int o = 0; o < 4; o++) begin
                opr[o] <= '0;
            end
        end else if (in_fire) begin
            for (int i = 0; i < OP_W; i++) begin
                if (i / DW == int'(wcnt)) begin
                    opr[ocnt][i] <= in_data[i % DW];
                end
            end
            if (wcnt == W_LAST) begin
                wcnt <= '0;
                ocnt <= ocnt + 2'd1;
            end else begin
                wcnt <= wcnt + WCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
            cycles  <= '0;
            rcnt    <= '0;
        end else begin
            if (state == ST_START) begin
                run_cnt <= '0;
            end else if (state == ST_RUN && run_cnt != '1) begin
                run_cnt <= run_cnt + CW'(1);
            end
            if (done_fire) begin
                cycles <= (run_cnt == '1) ? run_cnt : run_cnt + CW'(1);
            end
            if (out_fire) begin
                rcnt <= (rcnt == R_LAST) ? '0 : rcnt + RCW'(1);
            end
        end
    end

    assign core_x1 = opr[0];
    assign core_y1 = opr[1];
    assign core_x2 = opr[2];
    assign core_y2 = opr[3];

    host_word_shifter #(
        .DW(DW),
        .NO(NO),
        .RW(RES_W)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (done_fire),
        .load_data (core_out),
        .shift     (out_fire),
        .word      (out_data)
    );

endmodule

// File: tb/tb_tate_pairing_host_if.sv
// Randomized bench for tate_pairing_host_if with a latency-programmable core
// model and a reference model built from whole-operand arithmetic.
module tb_tate_pairing_host_if;

    localparam int DW = 32;
    localparam int CW = 32;
    localparam int NI = `TATE_NI(DW);
    localparam int NO = `TATE_NO(DW);
    localparam int OW = `WIDTH + 1;
    localparam int RW = `W6 + 1;
    localparam int PAD_SH = RW - (NO - 1) * DW;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_ready;
    logic            busy;
    logic [CW-1:0]   cycles;
    logic            core_reset;
    logic [`WIDTH:0] core_x1, core_y1, core_x2, core_y2;
    logic            core_done;
    logic [`W6:0]    res_val;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] job_words  [4*NI];
    logic [DW-1:0] next_words [4*NI];

    int   core_lat = 50;
    logic force_done;
    int   core_run_cnt;

    tate_pairing_host_if #(.DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .cycles     (cycles),
        .core_reset (core_reset),
        .core_x1    (core_x1),
        .core_y1    (core_y1),
        .core_x2    (core_x2),
        .core_y2    (core_y2),
        .core_done  (core_done),
        .core_out   (res_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: done appears in the core_lat-th cycle after its reset drops
    always @(posedge clk) begin
        if (core_reset) core_run_cnt <= 0;
        else            core_run_cnt <= core_run_cnt + 1;
    end
    assign core_done = force_done | (!core_reset && core_run_cnt >= core_lat - 1);

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [OW-1:0] model_operand(input int o);
        logic [NI*DW-1:0] acc;
        acc = '0;
        for (int k = 0; k < NI; k++) begin
            acc = acc | ((NI*DW)'(job_words[o*NI+k]) << (k*DW));
        end
        return acc[OW-1:0];
    endfunction

    function automatic logic [DW-1:0] model_word(input int k);
        logic [NO*DW-1:0] full;
        full = (NO*DW)'(res_val);
        full = full >> (k*DW);
        return full[DW-1:0];
    endfunction

    task automatic random_job();
        for (int i = 0; i < 4*NI; i++) job_words[i] = DW'({$urandom(), $urandom()});
    endtask

    task automatic random_result();
        logic [RW+31:0] tmp;
        for (int i = 0; i < RW; i += 32) tmp[i +: 32] = $urandom();
        res_val = tmp[RW-1:0];
    endtask

    // Streams the first n words of job_words, starting and ending on a negedge
    task automatic applyStimulus(input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = job_words[i];
            guard = 0;
            while (!in_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) begin
                checkOutput("in_ready_timeout", in_ready, 1);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit rand_ready);
        int k = 0;
        int guard = 0;
        while (k < NO && guard < NO * 40) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                checkOutput("out_data", out_data, model_word(k));
                checkOutput("out_last", out_last, k == NO - 1);
                if (out_ready) begin
                    if (k == NO - 1) checkOutput("last_pad", out_data >> PADSH_W(), 0);
                    k++;
                end
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        checkOutput("words_out", k, NO);
    endtask

    function automatic int PADSH_W();
        return PAD_SH;
    endfunction

    task automatic run_job(input int lat, input bit rand_ready, input bit force_load_done,
                           input bit hold_valid, input logic [DW-1:0] hold_data);
        logic [OW-1:0] e [4];
        int waited;
        core_lat = lat;
        for (int o = 0; o < 4; o++) e[o] = model_operand(o);
        force_done = force_load_done;
        applyStimulus(4*NI);
        checkOutput("start_core_reset", core_reset, 1);
        checkOutput("start_in_ready", in_ready, 0);
        checkOutput("start_out_valid", out_valid, 0);
        checkOutput("start_busy", busy, 1);
        force_done = 1'b0;
        if (hold_valid) begin
            in_valid = 1'b1;
            in_data  = hold_data;
        end
        @(negedge clk);
        checkOutput("run_core_reset", core_reset, 0);
        checkOutput("run_x1", core_x1, e[0]);
        checkOutput("run_y1", core_y1, e[1]);
        checkOutput("run_x2", core_x2, e[2]);
        checkOutput("run_y2", core_y2, e[3]);
        waited = 0;
        while (!out_valid && waited < lat + 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("unload_latency", waited, lat);
        checkOutput("cycles", cycles, lat);
        checkOutput("done_x1", core_x1, e[0]);
        checkOutput("done_y2", core_y2, e[3]);
        checkOutput("unload_in_ready", in_ready, 0);
        drain(rand_ready);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_in_ready", in_ready, 1);
        checkOutput("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        force_done = 1'b0;
        res_val    = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_cycles", cycles, 0);
        checkOutput("rst_core_reset", core_reset, 1);
        checkOutput("rst_x1", core_x1, 0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed job: small operands, counting result pattern");
        for (int i = 0; i < 4*NI; i++) job_words[i] = (i % NI == 0) ? DW'(i / NI + 1) : '0;
        begin
            logic [NO*DW-1:0] pat;
            pat = '0;
            for (int k = 0; k < NO; k++) pat = pat | ((NO*DW)'(k) << (k*DW));
            res_val = pat[RW-1:0];
        end
        checkOutput("model_x1_is_1", model_operand(0), 1);
        run_job(50, 1'b0, 1'b0, 1'b0, '0);

        $display("[TB] random job with random out_ready");
        random_job();
        random_result();
        run_job(37, 1'b1, 1'b0, 1'b0, '0);

        $display("[TB] abort after 10 words, then a fresh job");
        random_job();
        applyStimulus(10);
        checkOutput("abort_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_in_ready", in_ready, 1);
        checkOutput("abort_core_reset", core_reset, 1);
        checkOutput("abort_x1", core_x1, 0);
        checkOutput("abort_y1", core_y1, 0);
        random_job();
        random_result();
        run_job(20, 1'b1, 1'b0, 1'b0, '0);

        $display("[TB] core_done high during load, in_valid high during run");
        random_job();
        random_result();
        run_job(60, 1'b1, 1'b1, 1'b1, DW'($urandom()));
        in_valid = 1'b0;
        random_job();
        random_result();
        run_job(25, 1'b0, 1'b0, 1'b0, '0);

        $display("[TB] back-to-back jobs with in_valid held");
        random_job();
        random_result();
        for (int i = 0; i < 4*NI; i++) next_words[i] = DW'({$urandom(), $urandom()});
        run_job(30, 1'b1, 1'b0, 1'b1, next_words[0]);
        checkOutput("b2b_in_valid_ready", in_valid && in_ready, 1);
        job_words = next_words;
        random_result();
        run_job(45, 1'b0, 1'b0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
